// File: rtl/aging_priority_arbiter.sv
// Aging priority arbiter: grants the requester with the highest static priority
// plus age, breaks ties round-robin, and holds each grant for up to HOLD_CYCLES.
module aging_priority_arbiter #(
  parameter int N           = 8,
  parameter int PRIO_W      = 4,
  parameter int AGE_W       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int IDX_W       = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N*PRIO_W-1:0] prt,
  output logic                valid,
  output logic [IDX_W-1:0]    grant,
  output logic [N-1:0]        grant_onehot
);

  localparam int EFF_W = ((PRIO_W > AGE_W) ? PRIO_W : AGE_W) + 1;
  localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX   = '1;
  localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   N_EXT     = (IDX_W+1)'(N);
  localparam logic [N-1:0]     ONE_HOT0  = N'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [AGE_W-1:0] age [N];
  logic [HC_W-1:0]  hold_cnt;
  logic [IDX_W-1:0] ptr;
  logic [EFF_W-1:0] eff [N];
  logic [IDX_W-1:0] win_idx;
  logic             any_req;
  logic             hold_end;
  logic             arb;

  assign any_req = |req;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      eff[i] = EFF_W'(prt[i*PRIO_W +: PRIO_W]) + EFF_W'(age[i]);
    end
  end

  // Scan starts just after the last winner; only a strictly larger eff
  // displaces an earlier candidate, which gives the round-robin tie break.
  always_comb begin
    logic             found;
    logic [EFF_W-1:0] best;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    found   = 1'b0;
    best    = '0;
    sum     = '0;
    idx     = '0;
    win_idx = '0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      idx = (sum >= N_EXT) ? IDX_W'(sum - N_EXT) : IDX_W'(sum);
      if (req[idx] && (!found || eff[idx] > best)) begin
        found   = 1'b1;
        best    = eff[idx];
        win_idx = idx;
      end
    end
  end

  assign hold_end = (hold_cnt == HOLD_LAST) || !req[grant];
  assign arb      = (state == IDLE) ? any_req : (hold_end && any_req);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      valid        <= 1'b0;
      grant        <= '0;
      grant_onehot <= '0;
      hold_cnt     <= '0;
      ptr          <= PTR_INIT;
      for (int i = 0; i < N; i++) begin
        age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          age[i] <= '0;
        end else if (arb) begin
          if (IDX_W'(i) == win_idx) begin
            age[i] <= '0;
          end else if (age[i] != AGE_MAX) begin
            age[i] <= age[i] + 1'b1;
          end
        end
      end

      if (arb) begin
        state        <= GRANT;
        valid        <= 1'b1;
        grant        <= win_idx;
        grant_onehot <= ONE_HOT0 << win_idx;
        ptr          <= win_idx;
        hold_cnt     <= '0;
      end else if (state == GRANT) begin
        if (hold_end) begin
          // Nobody left requesting: grant keeps its last index on purpose.
          state        <= IDLE;
          valid        <= 1'b0;
          grant_onehot <= '0;
          hold_cnt     <= '0;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aging_priority_arbiter.sv
// Directed bench for aging_priority_arbiter: reset, round-robin ties, aging,
// early release, mid-hold priority change and a lone requester.
module tb_aging_priority_arbiter;

  localparam int N      = 8;
  localparam int PRIO_W = 4;
  localparam int IDX_W  = 3;
  localparam logic [N*PRIO_W-1:0] PRT_DEF = 32'h7545_5202;

  logic                clk;
  logic                rst;
  logic [N-1:0]        req;
  logic [N*PRIO_W-1:0] prt;
  logic                valid;
  logic [IDX_W-1:0]    grant;
  logic [N-1:0]        grant_onehot;

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [31:0] exp_q[$];

  aging_priority_arbiter #(
    .N(8), .PRIO_W(4), .AGE_W(4), .HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .prt(prt),
    .valid(valid), .grant(grant), .grant_onehot(grant_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with the given request vector, then release.
  task automatic do_reset(input logic [N-1:0] r);
    rst = 1'b0;
    req = r;
    prt = PRT_DEF;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Advance one cycle per queued expected grant and compare.
  task automatic run_grants(input string tag);
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check({tag, "_grant"}, 32'(grant), e);
      check({tag, "_valid"}, 32'(valid), 32'd1);
    end
  endtask

  task automatic push_grants(input int idx, input int cycles);
    for (int c = 0; c < cycles; c++) exp_q.push_back(32'(idx));
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    prt = PRT_DEF;

    // 1. reset behaviour and first grant
    do_reset(8'hFF);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_onehot", 32'(grant_onehot), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    push_grants(7, 6);
    run_grants("t1");
    check("t1_onehot", 32'(grant_onehot), 32'h80);
    rst = 1'b0;
    tick();
    check("t1_midrst_valid", 32'(valid), 32'd0);
    check("t1_midrst_onehot", 32'(grant_onehot), 32'd0);
    for (int i = 0; i < N; i++) check($sformatf("t1_age%0d", i), 32'(dut.age[i]), 32'd0);

    // 2. equal priorities alternate, 4 cycles each, no gap
    do_reset(8'h18);
    for (int r = 0; r < 4; r++) push_grants((r % 2 == 0) ? 3 : 4, 4);
    run_grants("t2");

    // 3. aging lifts port 0 to a tie on the 6th round
    do_reset(8'h81);
    push_grants(7, 20);
    push_grants(0, 4);
    push_grants(7, 4);
    run_grants("t3");

    // 4a. early release hands off to the best remaining port
    do_reset(8'h25);
    tick();
    check("t4_first_grant", 32'(grant), 32'd5);
    req = 8'h05;
    tick();
    check("t4_release_grant", 32'(grant), 32'd0);
    check("t4_release_valid", 32'(valid), 32'd1);
    check("t4_release_onehot", 32'(grant_onehot), 32'h01);

    // 4b. early release with nobody left goes idle, grant index kept
    do_reset(8'h20);
    tick();
    check("t4b_first_grant", 32'(grant), 32'd5);
    req = 8'h00;
    tick();
    check("t4b_idle_valid", 32'(valid), 32'd0);
    check("t4b_idle_onehot", 32'(grant_onehot), 32'd0);
    check("t4b_idle_grant", 32'(grant), 32'd5);

    // 5. priority change during a hold takes effect only at the next round
    do_reset(8'h81);
    tick();
    check("t5_first_grant", 32'(grant), 32'd7);
    prt[3:0] = 4'd15;
    push_grants(7, 3);
    push_grants(0, 1);
    run_grants("t5");
    check("t5_onehot", 32'(grant_onehot), 32'h01);
    prt = PRT_DEF;

    // 6. a lone requester is re-granted forever with age 0
    do_reset(8'h04);
    for (int c = 0; c < 12; c++) begin
      tick();
      check("t6_grant", 32'(grant), 32'd2);
      check("t6_valid", 32'(valid), 32'd1);
      check("t6_onehot", 32'(grant_onehot), 32'h04);
      check("t6_age2", 32'(dut.age[2]), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/aging_priority_arbiter.md
Name: aging_priority_arbiter

Overview:
- Shares one resource among N requesters using per-port 4-bit priorities (the same `prt` vector the demo top drives into the display digits).
- Each round grants the requester with the highest effective priority (static priority + age), breaking ties round-robin.
- The grant is held for HOLD_CYCLES so it stays visible on the LED dots. Ages guarantee that low-priority ports are eventually served.

Parameters:
- N, 8, number of requesters (≥2).
- PRIO_W, 4, static priority width per port.
- AGE_W, 4, age counter width per port (saturating).
- HOLD_CYCLES, 4, maximum cycles a grant is held (≥1).
- IDX_W, $clog2(N), grant index width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- req  in  N  request vector; bit i = port i.
- prt  in  N*PRIO_W  static priorities; port i at [i*PRIO_W +: PRIO_W].
- valid  out  1  a grant is active.
- grant  out  IDX_W  index of the granted port.
- grant_onehot  out  N  one-hot of grant; all zero when valid=0.

Behaviour:
- Reset (rst=0 at a clk edge, regardless of state):
  - state=IDLE, valid=0, grant=0, grant_onehot=0.
  - all ages=0, hold counter=0, round-robin pointer ptr=N-1.
- Effective priority: eff[i] = prt[i] + age[i], zero-extended to max(PRIO_W,AGE_W)+1 bits. No overflow possible.
- Winner selection (combinational, used only at arbitration edges):
  - Candidates are ports with req[i]=1.
  - Maximum eff wins. Ties go to the first candidate found scanning upward from (ptr+1) mod N, wrapping.
- Arbitration edge: any edge where the FSM selects a new grant. At that edge:
  - Register grant/onehot; set valid=1; ptr←winner; hold counter←0.
  - age[winner]←0.
  - Every other requesting port: age+1, saturating at 2^AGE_W-1.
- Ages of ports with req[i]=0 clear every cycle.
- prt is sampled only at arbitration edges. Changes during a hold have no effect.
- FSM states:
  - IDLE: valid=0. If |req at the edge → arbitration edge, go to GRANT. Latency: req high before edge t gives valid=1 after edge t.
  - GRANT: valid=1, grant stable. The hold ends when hold counter == HOLD_CYCLES-1, or req[grant]=0 (early release). Otherwise the counter increments.
  - At hold end: if |req → arbitration edge, stay in GRANT. valid stays 1 with no gap cycle. The current holder competes normally with age 0.
  - At hold end with req all zero → IDLE, valid=0, grant_onehot=0, grant keeps its last value.
- HOLD_CYCLES=1: re-arbitrate every cycle.
- Early release: because req[grant]=0 at that edge, the old holder is naturally excluded.
- Single requester: it is re-granted back-to-back indefinitely and its age stays 0.
- Starvation bound: a continuously requesting port of priority p wins no later than its (2^PRIO_W−1−p+1)-th lost round, provided AGE_W ≥ PRIO_W.
- Outputs are all registered. No combinational path from req/prt to outputs.

Test Plan:
(N=8, PRIO_W=4, AGE_W=4, HOLD_CYCLES=4; prt ports 0..7 = {2,0,2,5,5,4,5,7})
1. Reset: hold rst=0 for 2 cycles with req=8'hFF → valid=0, grant_onehot=0. Release rst → valid=1 one edge later with grant=7 (prio 7), held exactly 4 cycles. Assert rst=0 mid-hold → next edge valid=0 and all ages 0.
2. Tie round-robin: req=8'h18 from reset (ptr=7) → grant 3 first. Then 4 (aged eff 6), then 3 (aged eff 6; ptr=4, scan reaches 3 after 4 → wins on eff), alternating. Each grant lasts 4 cycles with valid continuously 1.
3. Aging/starvation: req=8'h81 → port 7 wins 5 rounds (20 cycles). On the 6th round port 0 reaches eff 7, ties with port 7, wins via ptr=7 → grant=0 at cycle 21. Then port 7 wins (age 1).
4. Early release: grant=5 active. Drop req[5] in hold cycle 1 → next edge grant becomes best remaining port, valid stays 1. With all req dropped instead → valid=0, grant_onehot=0 next edge.
5. Priority change mid-hold: port 7 granted. Set prt port 0 to 15 during hold → grant unchanged until hold end; next arbitration grants 0.
6. Single requester: req=8'h04 continuous → grant=2 every round, valid never drops. Confirm age[2] stays 0 and grant_onehot=8'h04.
